load_store_unit: RTL

- Core-side initiator for the SPRAM-backed `data_memory`.
- Accepts RV32I byte/halfword/word load and store requests from the core.
- Converts each byte address to the memory's 32-bit word address.
- Sub-word stores are done as read-modify-write, because the memory's byte masks are fixed full-width.
- Load results are aligned and sign- or zero-extended before being returned to the core.

---
 rtl/load_store_unit_if.sv | 30 +++
 rtl/load_store_unit.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/load_store_unit_if.sv
// Core request/response and data_memory bus bundle for load_store_unit.
// The slave modport is the LSU view; master is the core + memory side.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        mem_memwrite;
  logic        mem_memread;
  logic [31:0] mem_read_data;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_read_data,
    output req_ready, resp_valid, resp_rdata, resp_error,
    output mem_addr, mem_write_data, mem_memwrite, mem_memread
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_read_data,
    input  req_ready, resp_valid, resp_rdata, resp_error,
    input  mem_addr, mem_write_data, mem_memwrite, mem_memread
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store initiator for data_memory; sub-word stores use read-modify-write.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned accesses instead of force-aligning them.
//
// state | meaning
// IDLE  | ready for a request
// RD    | read strobe to memory
// RDW   | sample read data; extend (load) or merge (SB/SH)
// WR    | write strobe with full or merged word
// RESP  | one-cycle completion pulse
module load_store_unit (
  input  logic              clk,
  input  logic              rst_n,
  load_store_unit_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, RD, RDW, WR, RESP} state_t;

  state_t      state, state_next;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [1:0]  lane_q;
  logic        accept;
  logic        fault;
  logic [31:0] rdata_next;
  logic        error_next;

  function automatic logic is_invalid(input logic we, input logic [2:0] f3);
    if (we) return f3[2] | (f3[1:0] == 2'b11);
    else    return (f3[1:0] == 2'b11) | (f3[2:1] == 2'b11);
  endfunction

`ifdef LSU_MISALIGN_TRAP_EN
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lane);
    case (f3[1:0])
      2'b01:   return lane[0];
      2'b10:   return lane != 2'b00;
      default: return 1'b0;
    endcase
  endfunction
`endif

  // Halfword lane is addr[1] only, so misaligned offsets fall back to the aligned lane.
  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [2:0] f3,
                                              input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] data,
                                              input logic [2:0] f3, input logic [1:0] lane);
    logic [31:0] r;
    r = old;
    if (f3[1:0] == 2'b00) begin
      case (lane)
        2'b00:   r[7:0]   = data[7:0];
        2'b01:   r[15:8]  = data[7:0];
        2'b10:   r[23:16] = data[7:0];
        default: r[31:24] = data[7:0];
      endcase
    end else if (f3[1:0] == 2'b01) begin
      if (lane[1]) r[31:16] = data[15:0];
      else         r[15:0]  = data[15:0];
    end
    return r;
  endfunction

  assign accept = bus.req_valid & bus.req_ready;

`ifdef LSU_MISALIGN_TRAP_EN
  assign fault      = is_invalid(bus.req_we, bus.req_funct3) |
                      is_misaligned(bus.req_funct3, bus.req_addr[1:0]);
  assign error_next = (state == IDLE) & accept & fault;
`else
  assign fault      = is_invalid(bus.req_we, bus.req_funct3);
  assign error_next = 1'b0;
`endif

  assign rdata_next = (state == RDW && !we_q) ?
                      load_extend(bus.mem_read_data, funct3_q, lane_q) : 32'd0;

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (fault)                                     state_next = RESP;
          else if (bus.req_we && bus.req_funct3[1:0] == 2'b10) state_next = WR;
          else                                           state_next = RD;
        end
      end
      RD:      state_next = RDW;
      RDW:     state_next = we_q ? WR : RESP;
      WR:      state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are decoded from state_next so every port comes straight from a flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state              <= IDLE;
      we_q               <= 1'b0;
      funct3_q           <= 3'd0;
      lane_q             <= 2'd0;
      bus.req_ready      <= 1'b1;
      bus.resp_valid     <= 1'b0;
      bus.resp_rdata     <= 32'd0;
      bus.resp_error     <= 1'b0;
      bus.mem_addr       <= 32'd0;
      bus.mem_write_data <= 32'd0;
      bus.mem_memwrite   <= 1'b0;
      bus.mem_memread    <= 1'b0;
    end else begin
      state            <= state_next;
      bus.req_ready    <= (state_next == IDLE);
      bus.mem_memread  <= (state_next == RD);
      bus.mem_memwrite <= (state_next == WR);
      bus.resp_valid   <= (state_next == RESP);
      bus.resp_rdata   <= rdata_next;
      bus.resp_error   <= error_next;
      if (accept) begin
        we_q         <= bus.req_we;
        funct3_q     <= bus.req_funct3;
        lane_q       <= bus.req_addr[1:0];
        bus.mem_addr <= {2'b00, bus.req_addr[31:2]};
        if (bus.req_we) bus.mem_write_data <= bus.req_wdata;
      end else if (state == RDW && we_q) begin
        bus.mem_write_data <= store_merge(bus.mem_read_data, bus.mem_write_data,
                                          funct3_q, lane_q);
      end
    end
  end

endmodule
